frame_buffer_addr_gen: RTL and testbench

Parametrised SDRAM frame-buffer address generator. It replaces free-running write/read address counters with a double-buffered, multi-channel scheme. It sits between the pixel source/sink timing (camera write side, VGA read side) and the multi-port SDRAM controller. It produces per-channel write and read addresses and FIFO load pulses, and swaps ping-pong buffers only at frame boundaries so the display never shows a partially written frame.

---
 rtl/frame_buffer_addr_gen.sv | 158 +++++++++++++++
 tb/tb_frame_buffer_addr_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_addr_gen: ping-pong multi-channel SDRAM frame address gen.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module frame_buffer_addr_gen #(
  parameter int                NUM_CH     = 2,
  parameter int                ADDR_W     = 23,
  parameter int                H_ACTIVE   = 640,
  parameter int                V_ACTIVE   = 480,
  parameter logic [ADDR_W-1:0] CH_STRIDE  = 23'h100000,
  parameter logic [ADDR_W-1:0] BUF_OFFSET = 23'h080000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic                     wr_sof,
  input  logic                     rd_en,
  input  logic                     rd_sof,
  input  logic                     freeze,
  output logic                     wr_accept,
  output logic [NUM_CH*ADDR_W-1:0] wr_addr,
  output logic [NUM_CH*ADDR_W-1:0] rd_addr,
  output logic                     wr_load,
  output logic                     rd_load,
  output logic                     wr_buf,
  output logic                     rd_buf,
  output logic [7:0]               drop_cnt
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int IDX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [IDX_W-1:0] c_last = IDX_W'(FRAME_PIX - 1);

  localparam logic [63:0] c_need  = 64'(NUM_CH - 1) * 64'(CH_STRIDE) + 64'(BUF_OFFSET)
                                  + 64'(FRAME_PIX);
  localparam logic [63:0] c_space = 64'd1 << ADDR_W;

  if ((c_need > c_space) || (NUM_CH < 1) || (NUM_CH > 4)) begin : g_cfg_check
    $error("frame_buffer_addr_gen: channel/buffer map does not fit ADDR_W or NUM_CH out of 1..4");
  end

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_HOLD   = 2'd2
  } wr_state_t;

  // Every channel gets the same offset added to its own region base.
  function automatic logic [NUM_CH*ADDR_W-1:0] addr_vec(input logic [ADDR_W-1:0] off);
    logic [NUM_CH*ADDR_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[c*ADDR_W +: ADDR_W] = ADDR_W'(c) * CH_STRIDE + off;
    end
    return v;
  endfunction

  localparam logic [NUM_CH*ADDR_W-1:0] c_wr_rst = addr_vec('0);
  localparam logic [NUM_CH*ADDR_W-1:0] c_rd_rst = addr_vec(BUF_OFFSET);

  wr_state_t                wr_state_q, wr_state_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic                     wr_buf_q, wr_buf_d;
  logic                     rd_buf_q, rd_buf_d;
  logic [7:0]               drop_q, drop_d;
  logic                     wr_load_q, wr_load_d;
  logic                     rd_load_q, rd_load_d;
  logic [NUM_CH*ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [NUM_CH*ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0]         wr_use_idx, rd_use_idx;
  logic                     accept, swap;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    wr_buf_d   = wr_buf_q;
    rd_buf_d   = rd_buf_q;
    drop_d     = drop_q;
    accept     = 1'b0;

    // An sof pixel always lands on idx 0, whatever the counter held.
    wr_use_idx = wr_sof ? '0 : wr_idx_q;
    rd_use_idx = rd_sof ? '0 : rd_idx_q;
    swap       = rd_en && (rd_use_idx == c_last) && (wr_state_q == W_HOLD) && !freeze;

    case (wr_state_q)
      W_IDLE:   accept = wr_en && wr_sof;
      W_ACTIVE: accept = wr_en;
      W_HOLD: begin
        if (wr_en && wr_sof && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      end
      default:  wr_state_d = W_IDLE;
    endcase

    if (accept) begin
      if (wr_use_idx == c_last) begin
        wr_idx_d   = '0;
        wr_state_d = W_HOLD;
      end else begin
        wr_idx_d   = wr_use_idx + 1'b1;
        wr_state_d = W_ACTIVE;
      end
    end

    if (rd_en) rd_idx_d = (rd_use_idx == c_last) ? '0 : rd_use_idx + 1'b1;

    if (swap) begin
      wr_buf_d   = ~wr_buf_q;
      rd_buf_d   = ~rd_buf_q;
      wr_state_d = W_IDLE;
    end

    wr_load_d = (accept && wr_sof) || swap;
    rd_load_d = (rd_en && rd_sof) || swap;
    wr_addr_d = addr_vec((wr_buf_d ? BUF_OFFSET : '0) + ADDR_W'(wr_idx_d));
    rd_addr_d = addr_vec((rd_buf_d ? BUF_OFFSET : '0) + ADDR_W'(rd_idx_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= W_IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_buf_q   <= 1'b0;
      rd_buf_q   <= 1'b1;
      drop_q     <= '0;
      wr_load_q  <= 1'b0;
      rd_load_q  <= 1'b0;
      wr_addr_q  <= c_wr_rst;
      rd_addr_q  <= c_rd_rst;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_buf_q   <= wr_buf_d;
      rd_buf_q   <= rd_buf_d;
      drop_q     <= drop_d;
      wr_load_q  <= wr_load_d;
      rd_load_q  <= rd_load_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign wr_accept = accept;
  assign wr_addr   = wr_addr_q;
  assign rd_addr   = rd_addr_q;
  assign wr_load   = wr_load_q;
  assign rd_load   = rd_load_q;
  assign wr_buf    = wr_buf_q;
  assign rd_buf    = rd_buf_q;
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frame_buffer_addr_gen: directed vectors for frame_buffer_addr_gen.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_frame_buffer_addr_gen;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 23;
  localparam logic [ADDR_W-1:0] STRIDE = 23'h100;
  localparam logic [ADDR_W-1:0] OFF    = 23'h040;

  logic clk, reset_n;
  logic wr_en, wr_sof, rd_en, rd_sof, freeze;
  logic wr_accept, wr_load, rd_load, wr_buf, rd_buf;
  logic [NUM_CH*ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  frame_buffer_addr_gen #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .H_ACTIVE(4), .V_ACTIVE(2),
    .CH_STRIDE(STRIDE), .BUF_OFFSET(OFF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_sof(wr_sof), .rd_en(rd_en), .rd_sof(rd_sof), .freeze(freeze),
    .wr_accept(wr_accept), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_load(wr_load), .rd_load(rd_load), .wr_buf(wr_buf), .rd_buf(rd_buf),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic we, ws, re, rs;
    logic acc;
    logic [ADDR_W-1:0] wa0, ra0;
    logic wl, rl, wb, rb;
    logic [7:0] dc;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [ADDR_W-1:0] wa0, input logic [ADDR_W-1:0] ra0,
                            input logic wl, input logic rl, input logic wb, input logic rb,
                            input logic [7:0] dc);
    chk({tag, " wr_addr0"}, 32'(wr_addr[ADDR_W-1:0]), 32'(wa0));
    chk({tag, " wr_addr1"}, 32'(wr_addr[2*ADDR_W-1:ADDR_W]), 32'(wa0 + STRIDE));
    chk({tag, " rd_addr0"}, 32'(rd_addr[ADDR_W-1:0]), 32'(ra0));
    chk({tag, " rd_addr1"}, 32'(rd_addr[2*ADDR_W-1:ADDR_W]), 32'(ra0 + STRIDE));
    chk({tag, " wr_load"}, 32'(wr_load), 32'(wl));
    chk({tag, " rd_load"}, 32'(rd_load), 32'(rl));
    chk({tag, " wr_buf"}, 32'(wr_buf), 32'(wb));
    chk({tag, " rd_buf"}, 32'(rd_buf), 32'(rb));
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(dc));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic set_in(input logic we, input logic ws, input logic re, input logic rs);
    @(negedge clk);
    wr_en = we; wr_sof = ws; rd_en = re; rd_sof = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic we, input logic ws, input logic re, input logic rs);
    set_in(we, ws, re, rs);
    tick();
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    wr_en = 1'b0; wr_sof = 1'b0; rd_en = 1'b0; rd_sof = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_outs(tag, 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_sof = 1'b0; rd_en = 1'b0; rd_sof = 1'b0; freeze = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 23'h001, 23'h040, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    for (int i = 1; i <= 6; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'(i + 1), 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h000, 23'h041, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    for (int j = 10; j <= 15; j++)
      tbl[j] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000, 23'(23'h040 + 23'(j - 8)), 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h040, 23'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h040, 23'h000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Write one frame, refuse a 9th pixel, then read a frame and swap at the wrap.
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].we, tbl[i].ws, tbl[i].re, tbl[i].rs);
      chk($sformatf("v%0d wr_accept", i), 32'(wr_accept), 32'(tbl[i].acc));
      tick();
      check_outs($sformatf("v%0d", i), tbl[i].wa0, tbl[i].ra0, tbl[i].wl, tbl[i].rl,
                 tbl[i].wb, tbl[i].rb, tbl[i].dc);
    end

    // Dropped frames while holding, then saturation.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_outs("fill buf1", 23'h040, 23'h000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold sof wr_accept", 32'(wr_accept), 32'd0);
    tick();
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("drop3", 23'h040, 23'h000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    repeat (297) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop300 sat", 32'(drop_cnt), 32'd255);

    async_reset_check("reset after drops");

    // Freeze holds both buffers across two read wraps.
    freeze = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("freeze wrap1", 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("freeze wrap2", 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    freeze = 1'b0;
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("unfreeze pre", 23'h000, 23'h047, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("unfreeze swap", 23'h040, 23'h000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

    // Resync: wr_sof arriving at idx 5 restarts the frame.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resync pre idx5", 32'(wr_addr[ADDR_W-1:0]), 32'h45);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_outs("resync sof", 23'h041, 23'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resync idx7", 32'(wr_addr[ADDR_W-1:0]), 32'h47);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resync last accept", 32'(wr_accept), 32'd1);
    tick();
    chk("resync done addr", 32'(wr_addr[ADDR_W-1:0]), 32'h40);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resync hold accept", 32'(wr_accept), 32'd0);
    tick();

    // Reset with a swap pending mid-read: pending swap is lost.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pending drop1", 32'(drop_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pending rd idx3", 32'(rd_addr[ADDR_W-1:0]), 32'h03);
    async_reset_check("reset pending");
    step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_outs("post reset wrap", 23'h000, 23'h040, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
